rv32_multicycle_ctrl: RTL and testbench

//   Multi-cycle control FSM for the RV32I core. It consumes the one-hot instruction-class

---
 rtl/rv32_ctrl_pkg.sv | 75 +++++++
 rtl/ctrl_timeout.sv | 43 ++++
 rtl/rv32_multicycle_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_rv32_multicycle_ctrl.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_ctrl_pkg.sv
// Shared types for the RV32I multi-cycle controller.
//   state_e      FSM state, exported on state_o for debug
//   class_e      latched instruction class (ClsNone = nothing decoded yet)
//   *_sel_e      datapath mux encodings driven by the controller
//   classify()   one-hot flag vector -> class, ClsNone when not exactly one-hot
package rv32_ctrl_pkg;

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StTrap   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ClsNone,
    ClsR,
    ClsI,
    ClsLoad,
    ClsStore,
    ClsBranch,
    ClsJal,
    ClsJalr,
    ClsLui,
    ClsAuipc
  } class_e;

  typedef enum logic [1:0] {
    AluARs1  = 2'b00,
    AluAPc   = 2'b01,
    AluAZero = 2'b10
  } alu_a_sel_e;

  typedef enum logic {
    AluBRs2 = 1'b0,
    AluBImm = 1'b1
  } alu_b_sel_e;

  typedef enum logic [1:0] {
    PcPlus4  = 2'b00,
    PcImm    = 2'b01,
    PcRs1Imm = 2'b10
  } pc_sel_e;

  typedef enum logic [1:0] {
    WbAlu = 2'b00,
    WbMem = 2'b01,
    WbPc4 = 2'b10,
    WbImm = 2'b11
  } wb_sel_e;

  // Flag order: {r_type, i_type, load, store, branch, jal, jalr, lui, auipc}
  function automatic class_e classify(input logic [8:0] flags);
    class_e cls;
    cls = ClsNone;
    if ($countones(flags) == 1) begin
      unique case (flags)
        9'b1_0000_0000: cls = ClsR;
        9'b0_1000_0000: cls = ClsI;
        9'b0_0100_0000: cls = ClsLoad;
        9'b0_0010_0000: cls = ClsStore;
        9'b0_0001_0000: cls = ClsBranch;
        9'b0_0000_1000: cls = ClsJal;
        9'b0_0000_0100: cls = ClsJalr;
        9'b0_0000_0010: cls = ClsLui;
        9'b0_0000_0001: cls = ClsAuipc;
        default:        cls = ClsNone;
      endcase
    end
    return cls;
  endfunction

endpackage

// File: rtl/ctrl_timeout.sv
// Memory-request watchdog shared by the instruction and data handshakes.
//   clk_i      clock
//   rst_i      asynchronous reset, active-high
//   clr_i      return the count to zero (no request pending, or ack seen)
//   inc_i      a request is waiting without ack this cycle
//   expired_o  this is the MEM_TIMEOUT-th unacknowledged request cycle
module ctrl_timeout #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CntW-1:0] LastWait = CntW'(MEM_TIMEOUT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Fires while the limit-th wait is in progress, so an ack in that same cycle
  // (which suppresses inc_i) still wins.
  assign expired_o = inc_i && (cnt_q == LastWait);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rv32_multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32I core: FETCH, DECODE, EXEC, MEM, WB, TRAP.
//   clk, rst                 clock, asynchronous active-high reset
//   imem_ack, dmem_ack       memory handshake completions
//   r_type .. auipc          one-hot class flags from the type decoder (sampled in DECODE)
//   br_taken                 branch comparator result (used in EXEC)
//   imem_req, ir_we          fetch request and instruction-register load
//   dmem_req, dmem_we        data request and store qualifier
//   alu_a_sel, alu_b_sel     ALU operand selects
//   pc_we, pc_sel            PC update (one pulse per retired instruction) and source
//   rf_we, wb_sel            register-file write and writeback source
//   trap                     sticky fault flag
//   state_o, instret         debug state and retired-instruction counter
module rv32_multicycle_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  input  logic             r_type,
  input  logic             i_type,
  input  logic             load,
  input  logic             store,
  input  logic             branch,
  input  logic             jal,
  input  logic             jalr,
  input  logic             lui,
  input  logic             auipc,
  input  logic             br_taken,
  output logic             imem_req,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [1:0]       alu_a_sel,
  output logic             alu_b_sel,
  output logic             pc_we,
  output logic [1:0]       pc_sel,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic             trap,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret
);

  state_e           state_q, state_d;
  class_e           class_q, class_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic req_any, ack_any, tmo_inc, tmo_expired;

  // Derived from state alone so the watchdog path has no loop through the outputs.
  assign req_any = (state_q == StFetch) || (state_q == StMem);
  assign ack_any = ((state_q == StFetch) && imem_ack) || ((state_q == StMem) && dmem_ack);
  assign tmo_inc = req_any && !ack_any;

  ctrl_timeout #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timeout (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (!tmo_inc),
    .inc_i    (tmo_inc),
    .expired_o(tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    class_d   = class_q;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    alu_a_sel = AluARs1;
    alu_b_sel = AluBRs2;
    pc_we     = 1'b0;
    pc_sel    = PcPlus4;
    rf_we     = 1'b0;
    wb_sel    = WbAlu;
    trap      = 1'b0;

    // While rst is held the FSM sits in FETCH but must not request anything.
    if (!rst) begin
      unique case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_we   = 1'b1;
            state_d = StDecode;
          end else if (tmo_expired) begin
            state_d = StTrap;
          end
        end

        StDecode: begin
          class_d = classify({r_type, i_type, load, store, branch, jal, jalr, lui, auipc});
          state_d = (class_d == ClsNone) ? StTrap : StExec;
        end

        StExec: begin
          state_d = StWb;
          unique case (class_q)
            ClsR: ;
            ClsI, ClsJalr: alu_b_sel = AluBImm;
            ClsLoad, ClsStore: begin
              alu_b_sel = AluBImm;
              state_d   = StMem;
            end
            ClsAuipc: begin
              alu_a_sel = AluAPc;
              alu_b_sel = AluBImm;
            end
            ClsLui: begin
              alu_a_sel = AluAZero;
              alu_b_sel = AluBImm;
            end
            ClsBranch: begin
              pc_we   = 1'b1;
              pc_sel  = br_taken ? PcImm : PcPlus4;
              state_d = StFetch;
            end
            ClsJal: ;
            default: state_d = StTrap;
          endcase
        end

        StMem: begin
          dmem_req = 1'b1;
          dmem_we  = (class_q == ClsStore);
          if (dmem_ack) begin
            if (class_q == ClsStore) begin
              pc_we   = 1'b1;
              pc_sel  = PcPlus4;
              state_d = StFetch;
            end else begin
              state_d = StWb;
            end
          end else if (tmo_expired) begin
            state_d = StTrap;
          end
        end

        StWb: begin
          rf_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = StFetch;
          unique case (class_q)
            ClsLoad:        wb_sel = WbMem;
            ClsJal, ClsJalr: wb_sel = WbPc4;
            ClsLui:         wb_sel = WbImm;
            default:        wb_sel = WbAlu;
          endcase
          if (class_q == ClsJal) begin
            pc_sel = PcImm;
          end else if (class_q == ClsJalr) begin
            pc_sel = PcRs1Imm;
          end
        end

        StTrap: trap = 1'b1;

        default: state_d = StTrap;
      endcase
    end
  end

  assign instret_d = instret_q + CNT_W'(pc_we);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      class_q   <= ClsNone;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      instret_q <= instret_d;
    end
  end

  assign state_o = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_rv32_multicycle_ctrl.sv
// Bench for rv32_multicycle_ctrl: directed instruction table, hand-written fault
// sequences and random instruction streams, checked cycle by cycle against an
// instruction-level reference model.
module tb_rv32_multicycle_ctrl;

  localparam int unsigned MEM_TIMEOUT = 16;
  localparam int unsigned CNT_W       = 4;

  // State codes in the order the states are listed: FETCH..TRAP = 0..5
  localparam int PhFetch = 0, PhDecode = 1, PhExec = 2, PhMem = 3, PhWb = 4, PhTrap = 5;
  // Flag bit index per instruction class
  localparam int CR = 0, CI = 1, CLoad = 2, CStore = 3, CBranch = 4;
  localparam int CJal = 5, CJalr = 6, CLui = 7, CAuipc = 8;

  logic clk = 1'b0, rst = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0, br_taken = 1'b0;
  logic [8:0] flags = '0;

  logic imem_req, ir_we, dmem_req, dmem_we, alu_b_sel, pc_we, rf_we, trap;
  logic [1:0] alu_a_sel, pc_sel, wb_sel;
  logic [2:0] state_o;
  logic [CNT_W-1:0] instret;

  typedef struct packed {
    logic             imem_req;
    logic             ir_we;
    logic             dmem_req;
    logic             dmem_we;
    logic [1:0]       alu_a;
    logic             alu_b;
    logic             pc_we;
    logic [1:0]       pc_sel;
    logic             rf_we;
    logic [1:0]       wb_sel;
    logic             trap;
    logic [2:0]       state;
    logic [CNT_W-1:0] instret;
  } outs_t;

  typedef struct {
    logic [8:0] fl;
    int         fw;
    int         mw;
    logic       tk;
    int         cyc;
    int         dret;
  } vec_t;

  outs_t act;
  assign act = {imem_req, ir_we, dmem_req, dmem_we, alu_a_sel, alu_b_sel, pc_we, pc_sel,
                rf_we, wb_sel, trap, state_o, instret};

  int n_checks = 0;
  int n_fail   = 0;
  logic [CNT_W-1:0] exp_instret = '0;
  bit trapped = 1'b0;

  rv32_multicycle_ctrl #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .imem_ack (imem_ack),
    .dmem_ack (dmem_ack),
    .r_type   (flags[CR]),
    .i_type   (flags[CI]),
    .load     (flags[CLoad]),
    .store    (flags[CStore]),
    .branch   (flags[CBranch]),
    .jal      (flags[CJal]),
    .jalr     (flags[CJalr]),
    .lui      (flags[CLui]),
    .auipc    (flags[CAuipc]),
    .br_taken (br_taken),
    .imem_req (imem_req),
    .ir_we    (ir_we),
    .dmem_req (dmem_req),
    .dmem_we  (dmem_we),
    .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel),
    .pc_we    (pc_we),
    .pc_sel   (pc_sel),
    .rf_we    (rf_we),
    .wb_sel   (wb_sel),
    .trap     (trap),
    .state_o  (state_o),
    .instret  (instret)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] fl_of(input int idx);
    logic [8:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic int cls_of(input logic [8:0] fl);
    if ($countones(fl) != 1) return -1;
    for (int i = 0; i < 9; i++) if (fl[i]) return i;
    return -1;
  endfunction

  // Expected outputs for one cycle of a given phase of an instruction of class cls.
  function automatic outs_t model(input int ph, input int cls, input logic ack, input logic tk);
    outs_t o;
    o = '0;
    o.instret = exp_instret;
    o.state = 3'(ph);
    case (ph)
      PhFetch: begin
        o.imem_req = 1'b1;
        o.ir_we = ack;
      end
      PhExec: begin
        case (cls)
          CI, CLoad, CStore, CJalr: o.alu_b = 1'b1;
          CAuipc: begin o.alu_a = 2'b01; o.alu_b = 1'b1; end
          CLui:   begin o.alu_a = 2'b10; o.alu_b = 1'b1; end
          CBranch: begin o.pc_we = 1'b1; o.pc_sel = tk ? 2'b01 : 2'b00; end
          default: ;
        endcase
      end
      PhMem: begin
        o.dmem_req = 1'b1;
        o.dmem_we = (cls == CStore);
        if (ack && cls == CStore) o.pc_we = 1'b1;
      end
      PhWb: begin
        o.rf_we = 1'b1;
        o.pc_we = 1'b1;
        o.wb_sel = (cls == CLoad) ? 2'b01 : (cls == CJal || cls == CJalr) ? 2'b10 :
                   (cls == CLui) ? 2'b11 : 2'b00;
        o.pc_sel = (cls == CJal) ? 2'b01 : (cls == CJalr) ? 2'b10 : 2'b00;
      end
      PhTrap: o.trap = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic check(input string nm, input outs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
    if (exp.pc_we) exp_instret = exp_instret + 1'b1;
  endtask

  task automatic check_int(input string nm, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Called at a falling edge; inputs settle before the next rising edge.
  task automatic drive(input logic ia, input logic da, input logic [8:0] fl, input logic bt);
    imem_ack = ia;
    dmem_ack = da;
    flags    = fl;
    br_taken = bt;
    #1;
  endtask

  task automatic trap_tail();
    for (int i = 0; i < 3; i++) begin
      drive(1'($urandom), 1'($urandom), 9'($urandom), 1'($urandom));
      check("trap_hold", model(PhTrap, -1, 1'b0, 1'b0));
      @(negedge clk);
    end
    trapped = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'($urandom), 1'($urandom), 9'($urandom), 1'($urandom));
    check("reset_hold", '0);
    exp_instret = '0;
    trapped = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Runs one instruction from FETCH; fw/mw = wait cycles before ack (>= MEM_TIMEOUT: never).
  task automatic do_instr(input logic [8:0] fl, input int fw, input int mw, input logic tk,
                          input bit abort_mem, output int cycles);
    int cls;
    bit acked;
    cls = cls_of(fl);
    cycles = 0;
    acked = 1'b0;
    for (int c = 0; c < int'(MEM_TIMEOUT); c++) begin
      drive(c == fw, 1'($urandom), 9'($urandom), 1'($urandom));
      check("fetch", model(PhFetch, cls, imem_ack, 1'b0));
      cycles++;
      @(negedge clk);
      if (imem_ack) begin acked = 1'b1; break; end
    end
    if (!acked) begin trap_tail(); return; end

    drive(1'($urandom), 1'($urandom), fl, 1'($urandom));
    check("decode", model(PhDecode, cls, 1'b0, 1'b0));
    cycles++;
    @(negedge clk);
    if (cls < 0) begin trap_tail(); return; end

    // Scrambled flags from here on: the latched class must be used.
    drive(1'($urandom), 1'($urandom), 9'($urandom), tk);
    check("exec", model(PhExec, cls, 1'b0, tk));
    cycles++;
    @(negedge clk);
    if (cls == CBranch) return;

    if (cls == CLoad || cls == CStore) begin
      acked = 1'b0;
      for (int c = 0; c < int'(MEM_TIMEOUT); c++) begin
        drive(1'($urandom), c == mw, 9'($urandom), 1'($urandom));
        check("mem", model(PhMem, cls, dmem_ack, 1'b0));
        cycles++;
        if (abort_mem && c == 1) begin
          #1 rst = 1'b1;
          #1 check("rst_mid_mem", '0);
          exp_instret = '0;
          @(negedge clk);
          @(negedge clk);
          rst = 1'b0;
          trapped = 1'b0;
          return;
        end
        @(negedge clk);
        if (dmem_ack) begin acked = 1'b1; break; end
      end
      if (!acked) begin trap_tail(); return; end
      if (cls == CStore) return;
    end

    drive(1'($urandom), 1'($urandom), 9'($urandom), 1'($urandom));
    check("wb", model(PhWb, cls, 1'b0, 1'b0));
    cycles++;
    @(negedge clk);
  endtask

  function automatic int pick_wait();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 2) return 40;
    if (r < 5) return int'(MEM_TIMEOUT) - 1;
    return int'($urandom_range(0, 3));
  endfunction

  initial begin
    vec_t tbl[13];
    int cyc;
    logic [CNT_W-1:0] start;
    logic [CNT_W-1:0] want;

    tbl[0]  = '{fl_of(CR),      0,  0, 1'b0,  4, 1};
    tbl[1]  = '{fl_of(CLoad),   0,  3, 1'b0,  8, 1};
    tbl[2]  = '{fl_of(CBranch), 0,  0, 1'b1,  3, 1};
    tbl[3]  = '{fl_of(CBranch), 0,  0, 1'b0,  3, 1};
    tbl[4]  = '{fl_of(CStore),  0,  0, 1'b0,  4, 1};
    tbl[5]  = '{fl_of(CI),      2,  0, 1'b0,  6, 1};
    tbl[6]  = '{fl_of(CJal),    0,  0, 1'b0,  4, 1};
    tbl[7]  = '{fl_of(CJalr),   0,  0, 1'b1,  4, 1};
    tbl[8]  = '{fl_of(CLui),    0,  0, 1'b0,  4, 1};
    tbl[9]  = '{fl_of(CAuipc),  1,  0, 1'b0,  5, 1};
    tbl[10] = '{fl_of(CLoad),   0,  0, 1'b0,  5, 1};
    tbl[11] = '{fl_of(CStore), 15, 15, 1'b0, 34, 1};
    tbl[12] = '{fl_of(CLoad),   1, 15, 1'b0, 21, 1};

    #2 rst = 1'b1;
    #1 check("reset_state", '0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (tbl[i]) begin
      start = exp_instret;
      do_instr(tbl[i].fl, tbl[i].fw, tbl[i].mw, tbl[i].tk, 1'b0, cyc);
      check_int("latency", cyc, tbl[i].cyc);
      want = start + CNT_W'(tbl[i].dret);
      check_int("retired", int'(instret), int'(want));
    end

    // Illegal classes: no flag, then two flags.
    start = exp_instret;
    do_instr(9'b0, 0, 0, 1'b0, 1'b0, cyc);
    check_int("illegal_zero_trap", int'(trap), 1);
    check_int("illegal_zero_instret", int'(instret), int'(start));
    do_reset();
    do_instr(fl_of(CLoad) | fl_of(CStore), 0, 0, 1'b0, 1'b0, cyc);
    check_int("illegal_two_trap", int'(trap), 1);
    do_reset();

    // Watchdogs: no ack at all.
    do_instr(fl_of(CR), 100, 0, 1'b0, 1'b0, cyc);
    check_int("imem_timeout_cycles", cyc, int'(MEM_TIMEOUT));
    do_reset();
    do_instr(fl_of(CLoad), 0, 100, 1'b0, 1'b0, cyc);
    check_int("dmem_timeout_cycles", cyc, 3 + int'(MEM_TIMEOUT));
    do_reset();

    // Reset in the middle of a store's MEM wait, then normal operation.
    do_instr(fl_of(CR), 0, 0, 1'b0, 1'b0, cyc);
    do_instr(fl_of(CStore), 0, 100, 1'b0, 1'b1, cyc);
    do_instr(fl_of(CR), 0, 0, 1'b0, 1'b0, cyc);
    check_int("after_rst_latency", cyc, 4);
    check_int("after_rst_instret", int'(instret), 1);

    // Counter wrap.
    do_reset();
    for (int i = 0; i < (1 << CNT_W); i++) do_instr(fl_of(CBranch), 0, 0, 1'($urandom), 1'b0, cyc);
    check_int("instret_wrap", int'(instret), 0);

    // Random instruction stream.
    for (int k = 0; k < 300; k++) begin
      logic [8:0] f;
      int fw;
      int mw;
      if ($urandom_range(0, 99) < 4) begin
        f = 9'($urandom);
        if ($countones(f) == 1) f = '0;
      end else begin
        f = fl_of(int'($urandom_range(0, 8)));
      end
      fw = pick_wait();
      mw = pick_wait();
      do_instr(f, fw, mw, 1'($urandom), 1'b0, cyc);
      if (trapped) do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
